// File: rtl/press_gen_pkg.sv
// Shared encodings for the press_gen button emulator.
// PRESS_GEN_BOUNCE_EN adds the contact-bounce states.
package press_gen_pkg;

  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {
    ModeShort    = 2'b00,
    ModeLong     = 2'b01,
    ModeDouble   = 2'b10,
    ModeReserved = 2'b11
  } mode_e;

  localparam logic [1:0] RsvdMode = 2'b11;

`ifdef PRESS_GEN_BOUNCE_EN
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StBncIn  = 3'd1,
    StHold   = 3'd2,
    StBncOut = 3'd3,
    StGap    = 3'd4,
    StDone   = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StHold = 3'd2,
    StGap  = 3'd4,
    StDone = 3'd5
  } state_e;
`endif

  function automatic logic mode_valid(input logic [1:0] m);
    return m != RsvdMode;
  endfunction

endpackage

// File: rtl/press_gen_if.sv
// Request/status bundle between a press_gen user (master) and press_gen (slave).
interface press_gen_if;
  logic       start;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic       button;

  modport master (output start, output mode, input busy, input done, input button);
  modport slave (input start, input mode, output busy, output done, output button);
endinterface

// File: rtl/press_timer.sv
// Loadable 8-bit down-counter; term_o flags the last cycle of a phase (count == 1).
module press_timer
  import press_gen_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            term_o
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term_o = (count_q == CntW'(1));

endmodule

// File: rtl/press_gen.sv
// Button-press waveform generator: short, long and double presses.
// Define PRESS_GEN_BOUNCE_EN to wrap every hold phase in contact-bounce glitches.
module press_gen
  import press_gen_pkg::*;
#(
  parameter int unsigned SHORT_CYC  = 4,
  parameter int unsigned LONG_CYC   = 16,
  parameter int unsigned GAP_CYC    = 4,
  parameter int unsigned BOUNCE_CYC = 3
) (
  input logic        clk,
  input logic        rst,
  press_gen_if.slave bus
);

  if (SHORT_CYC < 1 || SHORT_CYC > 255 || LONG_CYC < 1 || LONG_CYC > 255 ||
      GAP_CYC < 1 || GAP_CYC > 255 || BOUNCE_CYC < 1 || BOUNCE_CYC > 255) begin : g_param_chk
    $error("press_gen: cycle parameters must lie in 1..255");
  end

  localparam logic [CntW-1:0] ShortLd = CntW'(SHORT_CYC);
  localparam logic [CntW-1:0] LongLd  = CntW'(LONG_CYC);
  localparam logic [CntW-1:0] GapLd   = CntW'(GAP_CYC);
`ifdef PRESS_GEN_BOUNCE_EN
  localparam logic [CntW-1:0] BncLd   = CntW'(BOUNCE_CYC);
`endif

  state_e          state_q;
  mode_e           mode_q;
  logic            second_q;
  logic            button_q, busy_q, done_q;
  logic            tmr_load, tmr_term;
  logic [CntW-1:0] tmr_val;
  logic            start_ok, need_gap;

  function automatic logic [CntW-1:0] hold_ld(input mode_e m);
    return (m == ModeLong) ? LongLd : ShortLd;
  endfunction

  assign start_ok = bus.start && mode_valid(bus.mode);
  // Only the first press of a double is followed by a gap.
  assign need_gap = (mode_q == ModeDouble) && !second_q;

  // Counter reload on every phase entry; the FSM below follows the same transitions.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          tmr_load = 1'b1;
`ifdef PRESS_GEN_BOUNCE_EN
          tmr_val  = BncLd;
`else
          tmr_val  = hold_ld(mode_e'(bus.mode));
`endif
        end
      end
`ifdef PRESS_GEN_BOUNCE_EN
      StBncIn: begin
        if (tmr_term) begin
          tmr_load = 1'b1;
          tmr_val  = hold_ld(mode_q);
        end
      end
      StHold: begin
        if (tmr_term) begin
          tmr_load = 1'b1;
          tmr_val  = BncLd;
        end
      end
      StBncOut: begin
        if (tmr_term && need_gap) begin
          tmr_load = 1'b1;
          tmr_val  = GapLd;
        end
      end
      StGap: begin
        if (tmr_term) begin
          tmr_load = 1'b1;
          tmr_val  = BncLd;
        end
      end
`else
      StHold: begin
        if (tmr_term && need_gap) begin
          tmr_load = 1'b1;
          tmr_val  = GapLd;
        end
      end
      StGap: begin
        if (tmr_term) begin
          tmr_load = 1'b1;
          tmr_val  = ShortLd;
        end
      end
`endif
      default: ;
    endcase
  end

  press_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .term_o     (tmr_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mode_q   <= ModeShort;
      second_q <= 1'b0;
      button_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            mode_q   <= mode_e'(bus.mode);
            second_q <= 1'b0;
            busy_q   <= 1'b1;
            button_q <= 1'b1;
`ifdef PRESS_GEN_BOUNCE_EN
            state_q  <= StBncIn;
`else
            state_q  <= StHold;
`endif
          end
        end
`ifdef PRESS_GEN_BOUNCE_EN
        StBncIn: begin
          if (tmr_term) begin
            button_q <= 1'b1;
            state_q  <= StHold;
          end else begin
            button_q <= ~button_q;
          end
        end
        StHold: begin
          if (tmr_term) begin
            button_q <= 1'b0;
            state_q  <= StBncOut;
          end
        end
        StBncOut: begin
          if (tmr_term) begin
            button_q <= 1'b0;
            if (need_gap) begin
              state_q <= StGap;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end else begin
            button_q <= ~button_q;
          end
        end
`else
        StHold: begin
          if (tmr_term) begin
            button_q <= 1'b0;
            if (need_gap) begin
              state_q <= StGap;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
`endif
        StGap: begin
          if (tmr_term) begin
            second_q <= 1'b1;
            button_q <= 1'b1;
`ifdef PRESS_GEN_BOUNCE_EN
            state_q  <= StBncIn;
`else
            state_q  <= StHold;
`endif
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          button_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.button = button_q;

endmodule
